// File: rtl/condicionador_teclas.sv
// Push-button conditioner: per-key 2-flop synchroniser, debounce, and a
// press/hold FSM producing registered press, release, short, long-hold and
// auto-repeat pulses. Keys are independent; one lane instance per key.

module condicionador_teclas_key #(
  parameter int DEBOUNCE_CYC  = 1_000_000,
  parameter int LONG_CYC      = 100_000_000,
  parameter int RPT_DELAY_CYC = 25_000_000,
  parameter int RPT_CYC       = 5_000_000,
  parameter bit RPT_EN        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);
  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W  = $clog2(LONG_CYC + 1);
  localparam int RPT_MAX = (RPT_DELAY_CYC > RPT_CYC) ? RPT_DELAY_CYC : RPT_CYC;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {ST_UP, ST_DOWN, ST_LONG} state_t;

  logic [1:0]        sync_q;
  logic              key_s;
  logic              acc_q, acc_d;        // accepted level, active-low like key_n
  logic [DB_W-1:0]   db_q, db_d;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [RPT_W-1:0]  rpt_q, rpt_d;
  logic              rdly_q, rdly_d;      // 1 while waiting for the first repeat
  logic              press_q, press_d, rel_q, rel_d, short_q, short_d;
  logic              long_q, long_d, rep_q, rep_d;
  logic              mismatch, flip, acc_press, acc_rel, rpt_hit;

  assign key_s = sync_q[1];

  // Two-flop synchroniser; resets to the released level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], key_n};
  end

  // Debounce: flip the accepted level after DEBOUNCE_CYC consecutive mismatches
  always_comb begin
    mismatch  = (key_s != acc_q);
    flip      = mismatch && (db_q == DB_W'(DEBOUNCE_CYC - 1));
    acc_d     = flip ? key_s : acc_q;
    db_d      = (mismatch && !flip) ? db_q + 1'b1 : '0;
    acc_press = flip && !key_s;
    acc_rel   = flip && key_s;
  end

  // Debounce state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= 1'b1;
      db_q  <= '0;
    end else begin
      acc_q <= acc_d;
      db_q  <= db_d;
    end
  end

  // Hold FSM next-state and pulse generation; a release always wins
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rpt_d   = rpt_q;
    rdly_d  = rdly_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    rpt_hit = rdly_q ? (rpt_q == RPT_W'(RPT_DELAY_CYC - 1))
                     : (rpt_q == RPT_W'(RPT_CYC - 1));
    case (state_q)
      ST_UP: begin
        if (acc_press) begin
          state_d = ST_DOWN;
          press_d = 1'b1;
          hold_d  = '0;
          rpt_d   = '0;
          rdly_d  = 1'b1;
        end
      end
      ST_DOWN: begin
        if (acc_rel) begin
          state_d = ST_UP;
          rel_d   = 1'b1;
          short_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_W'(LONG_CYC - 1)) begin
            state_d = ST_LONG;
            long_d  = 1'b1;
          end
        end
      end
      ST_LONG: begin
        if (acc_rel) begin
          state_d = ST_UP;
          rel_d   = 1'b1;
        end
      end
      default: state_d = ST_UP;
    endcase
    // Repeat counter runs from the press, in DOWN and LONG, until release
    if (RPT_EN && (state_q != ST_UP) && !acc_rel) begin
      if (rpt_hit) begin
        rep_d  = 1'b1;
        rpt_d  = '0;
        rdly_d = 1'b0;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  // FSM, counters and registered pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_UP;
      hold_q  <= '0;
      rpt_q   <= '0;
      rdly_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rpt_q   <= rpt_d;
      rdly_q  <= rdly_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end

  assign pressed       = (state_q != ST_UP);
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rep_q;
endmodule

module condicionador_teclas #(
  parameter int                N_KEYS        = 4,
  parameter int                DEBOUNCE_CYC  = 1_000_000,
  parameter int                LONG_CYC      = 100_000_000,
  parameter int                RPT_DELAY_CYC = 25_000_000,
  parameter int                RPT_CYC       = 5_000_000,
  parameter logic [N_KEYS-1:0] RPT_MASK      = 'b0010
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] short_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    condicionador_teclas_key #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .RPT_DELAY_CYC(RPT_DELAY_CYC),
      .RPT_CYC      (RPT_CYC),
      .RPT_EN       (RPT_MASK[i])
    ) u_key (
      .clk          (clk),
      .reset        (reset),
      .key_n        (key_n[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .short_pulse  (short_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end
endmodule

// File: tb/tb_condicionador_teclas.sv
// Bench for condicionador_teclas: scenario tasks plus a randomized run,
// compared every cycle against a held-count based reference model.

module tb_condicionador_teclas;
  localparam int NK = 4, D = 4, L = 20, RD = 8, RC = 3;
  localparam logic [NK-1:0] MASK = 4'b0010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] pressed, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse;

  condicionador_teclas #(
    .N_KEYS(NK), .DEBOUNCE_CYC(D), .LONG_CYC(L), .RPT_DELAY_CYC(RD), .RPT_CYC(RC), .RPT_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .short_pulse(short_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: key_s is key_n two edges late; a level is accepted after
  // D consecutive edges of disagreement; pulses follow from the held count.
  bit m_s1[NK], m_s2[NK], m_acc[NK], m_held[NK], m_ld[NK];
  int m_run[NK], m_k[NK];
  logic [NK-1:0] e_ps, e_pr, e_rl, e_sh, e_lg, e_rp;
  wire  [6*NK-1:0] obs = {pressed, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse};
  logic [6*NK-1:0] expv;

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      m_s1[i] = 1; m_s2[i] = 1; m_acc[i] = 1; m_held[i] = 0; m_ld[i] = 0;
      m_run[i] = 0; m_k[i] = 0;
    end
    {e_ps, e_pr, e_rl, e_sh, e_lg, e_rp} = '0;
    expv = '0;
  endtask

  task automatic model_edge();
    bit ev;
    {e_pr, e_rl, e_sh, e_lg, e_rp} = '0;
    for (int i = 0; i < NK; i++) begin
      ev = 0;
      if (m_s2[i] != m_acc[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin m_acc[i] = !m_acc[i]; m_run[i] = 0; ev = 1; end
      end else m_run[i] = 0;
      m_s2[i] = m_s1[i];
      m_s1[i] = key_n[i];
      if (ev && !m_acc[i]) begin
        e_pr[i] = 1; m_held[i] = 1; m_k[i] = 0; m_ld[i] = 0;
      end else if (ev && m_acc[i]) begin
        e_rl[i] = 1; e_sh[i] = !m_ld[i]; m_held[i] = 0;
      end else if (m_held[i]) begin
        m_k[i]++;
        if (m_k[i] == L && !m_ld[i]) begin e_lg[i] = 1; m_ld[i] = 1; end
        if (MASK[i] && m_k[i] >= RD && ((m_k[i] - RD) % RC) == 0) e_rp[i] = 1;
      end
      e_ps[i] = m_held[i];
    end
    expv = {e_ps, e_pr, e_rl, e_sh, e_lg, e_rp};
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_n = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_state: got %h expected 0", obs); end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_idle cyc %0d: got %h expected %h", c, obs, expv); end
    end
  endtask

  task automatic test_clean_press();
    int t_pr = -1, t_rl = -1, n_sh = 0, n_lg = 0;
    key_n[3] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 10) key_n[3] = 1'b1;
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL clean_press cyc %0d: got %h expected %h", c, obs, expv); end
      if (press_pulse[3] && t_pr < 0) t_pr = c;
      if (release_pulse[3] && t_rl < 0) t_rl = c - 10;
      if (short_pulse[3] && release_pulse[3]) n_sh++;
      if (long_pulse[3]) n_lg++;
    end
    checks++;
    if (t_pr !== 5) begin errors++; $display("FAIL clean_press_latency: got %0d expected 5", t_pr); end
    checks++;
    if (t_rl !== 5) begin errors++; $display("FAIL clean_release_latency: got %0d expected 5", t_rl); end
    checks++;
    if (n_sh !== 1 || n_lg !== 0) begin errors++; $display("FAIL clean_short_long: got short %0d long %0d expected 1 0", n_sh, n_lg); end
  endtask

  task automatic test_bounce();
    bit pat[] = '{0,0,0,1,0,0,0};
    int n_act = 0;
    for (int c = 0; c < 20; c++) begin
      key_n[0] = (c < 7) ? pat[c] : 1'b1;
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL bounce cyc %0d: got %h expected %h", c, obs, expv); end
      if (pressed[0] | press_pulse[0] | release_pulse[0] | short_pulse[0] | long_pulse[0]) n_act++;
    end
    checks++;
    if (n_act !== 0) begin errors++; $display("FAIL bounce_quiet: got %0d active cycles expected 0", n_act); end
  endtask

  task automatic test_long_hold();
    int t_pr = -1, t_lg = -1, n_lg = 0, n_rl = 0, n_sh = 0;
    key_n[0] = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c == 45) key_n[0] = 1'b1;
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL long_hold cyc %0d: got %h expected %h", c, obs, expv); end
      if (press_pulse[0]) t_pr = c;
      if (long_pulse[0]) begin t_lg = c; n_lg++; end
      if (release_pulse[0]) n_rl++;
      if (short_pulse[0]) n_sh++;
    end
    checks++;
    if (n_lg !== 1 || t_lg - t_pr !== L) begin errors++; $display("FAIL long_timing: got %0d pulses at +%0d expected 1 at +%0d", n_lg, t_lg - t_pr, L); end
    checks++;
    if (n_rl !== 1 || n_sh !== 0) begin errors++; $display("FAIL long_release: got release %0d short %0d expected 1 0", n_rl, n_sh); end
  endtask

  task automatic test_repeat();
    int t_pr = -1, n_both = 0, n_rp2 = 0;
    int got[$];
    int want[$] = '{8, 11, 14, 17, 20, 23};
    key_n[2:1] = 2'b00;
    for (int c = 0; c < 50; c++) begin
      if (t_pr >= 0 && c == t_pr + 25) key_n[2:1] = 2'b11;
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL repeat cyc %0d: got %h expected %h", c, obs, expv); end
      if (press_pulse[1] && press_pulse[2]) begin n_both++; t_pr = c; end
      if (repeat_pulse[1] && t_pr >= 0 && c - t_pr <= 25) got.push_back(c - t_pr);
      if (repeat_pulse[2]) n_rp2++;
    end
    checks++;
    if (got != want || n_both !== 1) begin errors++; $display("FAIL repeat_counts: got %p together %0d expected %p together 1", got, n_both, want); end
    checks++;
    if (n_rp2 !== 0) begin errors++; $display("FAIL repeat_mask: got %0d pulses on key 2 expected 0", n_rp2); end
  endtask

  task automatic test_reset_mid_hold();
    int n = 0, t_pr = -1;
    key_n[0] = 1'b0;
    while (!(m_held[0] && m_ld[0]) && n < 100) begin
      tick(); n++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL mid_hold cyc %0d: got %h expected %h", n, obs, expv); end
    end
    checks++;
    if (!(m_held[0] && m_ld[0]) || pressed[0] !== 1'b1) begin errors++; $display("FAIL mid_hold_reach: got pressed %b expected LONG reached", pressed[0]); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_async: got %h expected 0", obs); end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL after_reset cyc %0d: got %h expected %h", c, obs, expv); end
      if (press_pulse[0] && t_pr < 0) t_pr = c;
    end
    checks++;
    if (t_pr !== 6) begin errors++; $display("FAIL reset_repress: got edge %0d expected 6", t_pr); end
    key_n = '1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL after_reset_rel cyc %0d: got %h expected %h", c, obs, expv); end
    end
  endtask

  task automatic test_random();
    int left[NK];
    for (int i = 0; i < NK; i++) left[i] = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NK; i++) begin
        left[i]--;
        if (left[i] <= 0) begin
          key_n[i] = ~key_n[i];
          left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(4, 40));
        end
      end
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random cyc %0d: got %h expected %h", c, obs, expv); end
    end
    key_n = '1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random_settle cyc %0d: got %h expected %h", c, obs, expv); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_repeat();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
